// File: rtl/kd_pkg.sv
// Shared definitions for the Kyber/Dilithium unified adder job sequencer:
// op_mode encodings, moduli, default delay-line depths, FSM states and config bits.
package kd_pkg;

    localparam logic [2:0] K_NTT_PM = 3'd0;
    localparam logic [2:0] K_NTT_PP = 3'd1;
    localparam logic [2:0] K_INTT   = 3'd2;
    localparam logic [2:0] D_NTT    = 3'd3;
    localparam logic [2:0] D_INTT   = 3'd4;

    localparam int KQ = 3329;
    localparam int DQ = 8380417;

    localparam int LAT_K_DEF = 7;
    localparam int LAT_D_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } kd_state_e;

    typedef struct packed {
        logic kd_mode;
        logic sel_k_4_ntt;
        logic sel_d_2_ntt;
        logic sel_out;
    } kd_cfg_t;

endpackage

// File: rtl/kd_adder_ctrl_if.sv
// Scheduler <-> sequencer <-> adder/RAM signal bundle. The perf_cycles counter
// is present only when KD_CTRL_PERF_EN is defined.
interface kd_adder_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [2:0]       op_mode;
    logic [CNT_W-1:0] op_count;
    logic             src_valid;
    logic             src_ready;
    logic [CNT_W-1:0] rd_addr;
    logic             kd_mode;
    logic             sel_k_4_ntt;
    logic             sel_d_2_ntt;
    logic             sel_out;
    logic             res_valid;
    logic [CNT_W-1:0] wr_addr;
    logic             busy;
    logic             done;
    logic             err;
`ifdef KD_CTRL_PERF_EN
    logic [15:0]      perf_cycles;
`endif

    modport master (
        output start, op_mode, op_count, src_valid,
        input  src_ready, rd_addr, kd_mode, sel_k_4_ntt, sel_d_2_ntt, sel_out,
        input  res_valid, wr_addr, busy, done, err
`ifdef KD_CTRL_PERF_EN
        , input perf_cycles
`endif
    );

    modport slave (
        input  start, op_mode, op_count, src_valid,
        output src_ready, rd_addr, kd_mode, sel_k_4_ntt, sel_d_2_ntt, sel_out,
        output res_valid, wr_addr, busy, done, err
`ifdef KD_CTRL_PERF_EN
        , output perf_cycles
`endif
    );

endinterface

// File: rtl/kd_mode_decode.sv
// Combinational decode of op_mode into adder control bits, pipeline fill
// length L (beats swallowed by the operand delay line) and a legality flag.
module kd_mode_decode
    import kd_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int LAT_K = LAT_K_DEF,
    parameter int LAT_D = LAT_D_DEF
) (
    input  logic [2:0]       op_mode,
    output kd_cfg_t          cfg,
    output logic [CNT_W-1:0] fill,
    output logic             legal
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        cfg   = '0;
        fill  = '0;
        legal = 1'b0;
        case (op_mode)
            K_NTT_PM: begin
                cfg.sel_k_4_ntt = 1'b1;
                fill            = CNT_W'(LAT_K);
                legal           = 1'b1;
            end
            K_NTT_PP: begin
                cfg.sel_k_4_ntt = 1'b1;
                cfg.sel_out     = 1'b1;
                fill            = CNT_W'(LAT_K);
                legal           = 1'b1;
            end
            K_INTT: begin
                legal = 1'b1;
            end
            D_NTT: begin
                cfg.kd_mode     = 1'b1;
                cfg.sel_d_2_ntt = 1'b1;
                fill            = CNT_W'(LAT_D);
                legal           = 1'b1;
            end
            D_INTT: begin
                cfg.kd_mode = 1'b1;
                legal       = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/kd_adder_ctrl.sv
// Job sequencer for the unified Kyber/Dilithium modular adder: IDLE/RUN/DONE FSM,
// beat counter and result addressing. Optional KD_CTRL_PERF_EN adds perf_cycles.
module kd_adder_ctrl
    import kd_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int LAT_K = LAT_K_DEF,
    parameter int LAT_D = LAT_D_DEF
) (
    input  logic           clk,
    input  logic           rst,
    kd_adder_ctrl_if.slave bus
);

    kd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    kd_cfg_t          cfg_q, cfg_d;
    logic             err_q, err_d;

    kd_cfg_t          dec_cfg;
    logic [CNT_W-1:0] dec_fill;
    logic             dec_legal;
    logic             accept;
    logic             run;

    kd_mode_decode #(
        .CNT_W (CNT_W),
        .LAT_K (LAT_K),
        .LAT_D (LAT_D)
    ) u_decode (
        .op_mode (bus.op_mode),
        .cfg     (dec_cfg),
        .fill    (dec_fill),
        .legal   (dec_legal)
    );

    assign run    = (state_q == RUN);
    // A job must outlast its fill, otherwise it would produce no results.
    assign accept = (state_q == IDLE) && bus.start && dec_legal && (bus.op_count >= dec_fill);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        fill_d  = fill_q;
        cfg_d   = cfg_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    last_d  = bus.op_count;
                    fill_d  = dec_fill;
                    cfg_d   = dec_cfg;
                end else if (bus.start) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                // The delay lines never stall, so a missing beat corrupts the job.
                if (!bus.src_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (cnt_q == last_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the reset is asynchronous and sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            fill_q  <= '0;
            cfg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            fill_q  <= fill_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
        end
    end

    assign bus.src_ready   = run;
    assign bus.rd_addr     = cnt_q;
    assign bus.kd_mode     = run & cfg_q.kd_mode;
    assign bus.sel_k_4_ntt = run & cfg_q.sel_k_4_ntt;
    assign bus.sel_d_2_ntt = run & cfg_q.sel_d_2_ntt;
    assign bus.sel_out     = run & cfg_q.sel_out;
    assign bus.res_valid   = run & bus.src_valid & (cnt_q >= fill_q);
    assign bus.wr_addr     = bus.res_valid ? (cnt_q - fill_q) : '0;
    assign bus.busy        = run;
    assign bus.done        = (state_q == DONE);
    assign bus.err         = err_q;

`ifdef KD_CTRL_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (run && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_kd_adder_ctrl.sv
// Scoreboard bench for kd_adder_ctrl: directed plan cases plus random jobs,
// expected results derived from the job rules and checked by a monitor process.
module tb_kd_adder_ctrl;

    localparam int CNT_W = 8;

    logic clk;
    logic rst;

    kd_adder_ctrl_if #(.CNT_W(CNT_W)) bus ();

    kd_adder_ctrl #(.CNT_W(CNT_W), .LAT_K(7), .LAT_D(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected result: {wr_addr, kd_mode, sel_k_4_ntt, sel_d_2_ntt, sel_out}
    logic [11:0] exp_q[$];
    // Expected terminal events: "D" = done, "E" = err
    string       ev_q[$];
    logic [3:0]  cur_cfg;
    int          perf_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fill_len(input int mode);
        if (mode == 0 || mode == 1) return 7;
        if (mode == 3) return 6;
        return 0;
    endfunction

    function automatic logic [3:0] mode_cfg(input int mode);
        return {mode >= 3, mode <= 1, mode == 3, mode == 1};
    endfunction

    function automatic bit job_legal(input int mode, input int count);
        return (mode <= 4) && (count + 1 > fill_len(mode));
    endfunction

    // drop < 0: all beats present; otherwise src_valid falls at beat index drop
    task automatic run_job(input int mode, input int count, input int drop, input bit noise);
        bit ok;
        int beats_seen;
        ok = job_legal(mode, count);
        if (ok) begin
            cur_cfg = mode_cfg(mode);
            for (int i = fill_len(mode); i <= count; i++) begin
                if (drop >= 0 && i >= drop) break;
                exp_q.push_back({8'(i - fill_len(mode)), cur_cfg});
            end
            ev_q.push_back((drop >= 0) ? "E" : "D");
        end else begin
            ev_q.push_back("E");
        end
        bus.start     = 1'b1;
        bus.op_mode   = 3'(mode);
        bus.op_count  = CNT_W'(count);
        bus.src_valid = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        beats_seen = 0;
        if (ok) begin
            for (int k = 0; k <= count; k++) begin
                bus.src_valid = (k != drop);
                if (noise && ($urandom_range(0, 3) == 0)) begin
                    bus.start    = 1'b1;
                    bus.op_mode  = 3'($urandom_range(0, 7));
                    bus.op_count = CNT_W'($urandom);
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                check("rd_addr", bus.rd_addr, k);
                check("src_ready", bus.src_ready, 1);
                @(posedge clk); #1;
                beats_seen++;
                if (k == drop) break;
            end
            bus.src_valid = 1'b0;
            bus.start     = (noise && drop < 0);
            perf_exp      = beats_seen;
        end else begin
            @(negedge clk);
            check("reject_busy", bus.busy, 0);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", bus.busy, 0);
`ifdef KD_CTRL_PERF_EN
        check("perf_cycles", bus.perf_cycles, perf_exp);
`endif
    endtask

    // Monitor: compares every presented result and terminal pulse with the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_valid) begin
                check("res_valid_expected", bus.res_valid, exp_q.size() != 0);
                if (exp_q.size() != 0)
                    check("result", {bus.wr_addr, bus.kd_mode, bus.sel_k_4_ntt,
                                     bus.sel_d_2_ntt, bus.sel_out}, exp_q.pop_front());
            end
            if (bus.done || bus.err) begin
                check("event_pending", ev_q.size() != 0, 1);
                if (ev_q.size() != 0) begin
                    if (ev_q.pop_front() == "D") check("done_pulse", {bus.done, bus.err}, 2'b10);
                    else                         check("err_pulse", {bus.done, bus.err}, 2'b01);
                end
            end
            if (bus.busy)
                check("run_cfg", {bus.kd_mode, bus.sel_k_4_ntt, bus.sel_d_2_ntt, bus.sel_out}, cur_cfg);
            if (bus.done)
                check("done_busy", bus.busy, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.start     = 1'b0;
        bus.op_mode   = '0;
        bus.op_count  = '0;
        bus.src_valid = 1'b0;
        cur_cfg       = '0;
        perf_exp      = 0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.src_ready, bus.rd_addr, bus.kd_mode, bus.sel_k_4_ntt,
                                bus.sel_d_2_ntt, bus.sel_out, bus.res_valid, bus.wr_addr,
                                bus.busy, bus.done, bus.err}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed plan cases
        run_job(2, 3, -1, 0);
        run_job(0, 15, -1, 0);
        run_job(3, 9, -1, 0);
        run_job(6, 3, -1, 0);
        run_job(0, 6, -1, 0);
        run_job(0, 7, -1, 0);
        run_job(3, 5, -1, 0);
        run_job(3, 6, -1, 0);
        run_job(4, 7, 3, 0);
        run_job(4, 7, -1, 0);
        run_job(2, 0, -1, 0);
        run_job(2, 255, -1, 0);

        // Asynchronous reset in the middle of a mode-1 job
        cur_cfg       = mode_cfg(1);
        bus.start     = 1'b1;
        bus.op_mode   = 3'd1;
        bus.op_count  = 8'd20;
        bus.src_valid = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {bus.src_ready, bus.rd_addr, bus.kd_mode, bus.sel_k_4_ntt,
                                      bus.sel_d_2_ntt, bus.sel_out, bus.res_valid, bus.wr_addr,
                                      bus.busy, bus.done, bus.err}, 0);
        exp_q.delete();
        ev_q.delete();
        perf_exp = 0;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.src_valid = 1'b0;
        @(posedge clk); #1;
        run_job(1, 9, -1, 0);

        // Random jobs, with stray starts during RUN/DONE and occasional underruns
        for (int j = 0; j < 40; j++) begin
            int mode, count, drop;
            mode  = $urandom_range(0, 7);
            count = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            drop  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, count) : -1;
            run_job(mode, count, drop, 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("results_drained", exp_q.size(), 0);
        check("events_drained", ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
